confirm_input_ctrl: RTL and testbench

- Board-side producer for the CPU's `confirm`/`din` input handshake.
- Synchronizes the raw push-button and 16 slide switches, and debounces the button.
- Drives a clean, glitch-free `confirm` level plus a `din` word latched at the moment of a debounced press.
- Sits between the top-level pins and the CPU; `din` is stable for the whole time `confirm` is high.

---
 rtl/io_pkg.sv | 19 +
 rtl/sync_2ff.sv | 31 +++
 rtl/confirm_input_ctrl.sv | 118 +++++++++++
 tb/tb_confirm_input_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the board-side confirm/din input path.
package io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEBOUNCE_SIM   = 4;
    localparam int DEBOUNCE_BOARD = 2_000_000;
    localparam int SYNC_DEPTH     = 2;

    function automatic logic is_wait(input state_t s);
        return (s == ST_PRESS_WAIT) || (s == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-bit flip-flop synchronizer; each bit is independent (no bus coherency).
module sync_2ff
    import io_pkg::*;
#(
    parameter int W      = 1,
    parameter int STAGES = SYNC_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sync [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/confirm_input_ctrl.sv
// Debounced confirm push-button with a switch word latched on each accepted press.
module confirm_input_ctrl
    import io_pkg::*;
#(
    parameter int DIN_W           = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int SYNC_STAGES     = SYNC_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic [DIN_W-1:0] sw_raw,
    output logic             confirm,
    output logic [DIN_W-1:0] din,
    output logic             press_pulse,
    output logic             busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic             w_btn_s;
    logic [DIN_W-1:0] w_sw_s;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_confirm;
    logic [DIN_W-1:0] r_din;
    logic             r_pulse;
    logic             r_busy;

    sync_2ff #(
        .W      (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_btn (
        .clk (clk),
        .rst (rst),
        .i_d (btn_raw),
        .o_q (w_btn_s)
    );

    sync_2ff #(
        .W      (DIN_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_sw (
        .clk (clk),
        .rst (rst),
        .i_d (sw_raw),
        .o_q (w_sw_s)
    );

    // Counter is cleared on every wait-state entry, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_confirm <= 1'b0;
            r_din     <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_btn_s) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_btn_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == LAST) begin
                        r_state   <= ST_PRESSED;
                        r_din     <= w_sw_s;
                        r_confirm <= 1'b1;
                        r_pulse   <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    // Bounce back to PRESSED: no new pulse, din untouched.
                    if (w_btn_s) begin
                        r_state <= ST_PRESSED;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == LAST) begin
                        r_state   <= ST_IDLE;
                        r_confirm <= 1'b0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign confirm     = r_confirm;
    assign din         = r_din;
    assign press_pulse = r_pulse;
    assign busy        = r_busy;

endmodule

// File: tb/tb_confirm_input_ctrl.sv
// Scoreboard bench for confirm_input_ctrl with N=4 debounce.
module tb_confirm_input_ctrl;

    localparam int W = 16;
    localparam int N = 4;
    localparam int LAT = N + 3;

    typedef struct {
        logic [W-1:0] din;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_raw;
    logic [W-1:0] sw_raw;
    logic         confirm;
    logic [W-1:0] din;
    logic         press_pulse;
    logic         busy;

    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_push  = 0;
    int   n_pulse = 0;
    int   edge_cnt = 0;
    exp_t q [$];

    logic seen_hi;
    logic seen_lo;
    logic seen_busy;

    confirm_input_ctrl #(
        .DIN_W           (W),
        .DEBOUNCE_CYCLES (N),
        .SYNC_STAGES     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .sw_raw      (sw_raw),
        .confirm     (confirm),
        .din         (din),
        .press_pulse (press_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (press_pulse === 1'b1) begin
            n_pulse++;
            if (q.size() == 0) begin
                chk("unexpected_pulse", 32'(edge_cnt), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_din", 32'(din), 32'(e.din));
                chk("pulse_cycle", 32'(edge_cnt), 32'(e.cyc));
                chk("pulse_confirm", 32'(confirm), 32'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (confirm === 1'b1) seen_hi = 1'b1;
            if (confirm !== 1'b1) seen_lo = 1'b1;
            if (busy === 1'b1) seen_busy = 1'b1;
        end
    endtask

    task automatic clear_seen();
        seen_hi = 1'b0;
        seen_lo = 1'b0;
        seen_busy = 1'b0;
    endtask

    // Called on a negedge; next posedge is edge 1 of the press.
    task automatic press_expect(input logic [W-1:0] sw);
        exp_t e;
        sw_raw  = sw;
        btn_raw = 1'b1;
        e.din = sw;
        e.cyc = edge_cnt + LAT;
        q.push_back(e);
        n_push++;
        tick(LAT - 1);
        chk("press_early", 32'(confirm), 32'd0);
        tick(1);
        chk("press_rise", 32'(confirm), 32'd1);
    endtask

    task automatic release_expect(input logic [W-1:0] din_exp);
        btn_raw = 1'b0;
        tick(LAT - 1);
        chk("release_early", 32'(confirm), 32'd1);
        tick(1);
        chk("release_fall", 32'(confirm), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_din", 32'(din), 32'(din_exp));
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 1'b1;
        sw_raw  = 16'hFFFF;
        clear_seen();

        // Reset held with button and switches active
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_confirm", 32'(confirm), 32'd0);
            chk("rst_din", 32'(din), 32'd0);
            chk("rst_pulse", 32'(press_pulse), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;
        press_expect(16'hFFFF);
        release_expect(16'hFFFF);
        tick(3);

        // Clean press, button held 40 cycles
        press_expect(16'h0002);
        tick(40 - LAT);
        chk("hold_confirm", 32'(confirm), 32'd1);
        chk("hold_din", 32'(din), 32'h0002);
        release_expect(16'h0002);
        tick(3);

        // Bounce on press
        clear_seen();
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(1);
        btn_raw = 1'b1;
        tick(2);
        btn_raw = 1'b0;
        tick(15);
        chk("bounce_no_confirm", 32'(seen_hi), 32'd0);
        chk("bounce_busy_seen", 32'(seen_busy), 32'd1);
        chk("bounce_busy_end", 32'(busy), 32'd0);
        chk("bounce_din", 32'(din), 32'h0002);

        // Bounce on release
        press_expect(16'h0004);
        clear_seen();
        btn_raw = 1'b0;
        tick(2);
        btn_raw = 1'b1;
        tick(15);
        chk("rbounce_no_drop", 32'(seen_lo), 32'd0);
        chk("rbounce_busy_seen", 32'(seen_busy), 32'd1);
        chk("rbounce_din", 32'(din), 32'h0004);
        release_expect(16'h0004);
        tick(3);

        // Switch change while held is ignored
        press_expect(16'h0002);
        sw_raw = 16'h0001;
        tick(10);
        chk("swhold_din", 32'(din), 32'h0002);
        release_expect(16'h0002);
        tick(3);
        press_expect(16'h0001);
        chk("second_din", 32'(din), 32'h0001);
        release_expect(16'h0001);
        tick(3);

        // Reset in PRESS_WAIT with cnt==2
        clear_seen();
        btn_raw = 1'b1;
        tick(5);
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        btn_raw = 1'b0;
        tick(1);
        chk("mid_busy_post", 32'(busy), 32'd0);
        chk("mid_confirm", 32'(confirm), 32'd0);
        chk("mid_din", 32'(din), 32'd0);
        rst = 1'b0;
        tick(15);
        chk("mid_never_confirm", 32'(seen_hi), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("pulse_count", 32'(n_pulse), 32'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
